// File: rtl/pulse_window_ctrl.sv
// Delayed pulse window: after trig, wait delay_val+1 cycles, then drive pulse_out for width_val cycles.
// Optional restart-on-retrigger behaviour is selected by defining PULSE_WINDOW_RETRIG_EN.
module pulse_window_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             trig,
    input  logic             abort,
    input  logic [WIDTH-1:0] delay_val,
    input  logic [WIDTH-1:0] width_val,
    output logic             pulse_out,
    output logic             busy,
    output logic             done,
    output logic             trig_miss
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] wlat_q, wlat_d;
    logic             pulse_q, pulse_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             miss_q, miss_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wlat_d  = wlat_q;
        pulse_d = pulse_q;
        done_d  = 1'b0;
        miss_d  = 1'b0;

        // Normal progression of the window; abort and retrigger override below.
        case (state_q)
            IDLE: begin
                if (trig && !abort) begin
                    wlat_d  = width_val;
                    cnt_d   = delay_val;
                    state_d = DELAY;
                end
            end
            DELAY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (wlat_q != '0) begin
                    cnt_d   = wlat_q - 1'b1;
                    state_d = ACTIVE;
                    pulse_d = 1'b1;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            ACTIVE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = IDLE;
                    pulse_d = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                pulse_d = 1'b0;
            end
        endcase

        if (state_q != IDLE) begin
            if (abort) begin
                state_d = IDLE;
                cnt_d   = '0;
                pulse_d = 1'b0;
                done_d  = 1'b0;
            end else if (trig) begin
`ifdef PULSE_WINDOW_RETRIG_EN
                wlat_d  = width_val;
                cnt_d   = delay_val;
                state_d = DELAY;
                pulse_d = 1'b0;
                done_d  = 1'b0;
`else
                miss_d  = 1'b1;
`endif
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wlat_q  <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            miss_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wlat_q  <= wlat_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            miss_q  <= miss_d;
        end
    end

    assign pulse_out = pulse_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign trig_miss = miss_q;

endmodule
